alu_mdu: RTL

Parametrised, handshaked successor to the single-cycle integer ALU: executes all RV32I/RV64I base ALU operations with one cycle of latency, and the RISC-V M-extension multiply/divide operations iteratively over several cycles. It sits in the execute stage of the multi-cycle and pipelined cores. A valid/ready pair on each side lets the control path stall while a long operation is in flight. One operation is outstanding at a time.

---
 rtl/alu_pkg.sv | 36 +++
 rtl/alu_mdu_if.sv | 29 ++
 rtl/mdu_iter.sv | 113 +++++++++++
 rtl/alu_mdu.sv | 129 ++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared op codes, FSM state type and counter sizing for the ALU/MDU execute block.
// No logic; imported by alu_mdu_if, mdu_iter and alu_mdu.
// Backpressure: n/a.
package alu_pkg;
    localparam int XLEN_DEF = 32;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_SLL  = 4'd2;
    localparam logic [3:0] OP_SLT  = 4'd3;
    localparam logic [3:0] OP_SLTU = 4'd4;
    localparam logic [3:0] OP_XOR  = 4'd5;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_SRA  = 4'd7;
    localparam logic [3:0] OP_OR   = 4'd8;
    localparam logic [3:0] OP_AND  = 4'd9;

    localparam logic [2:0] F3_MUL    = 3'd0;
    localparam logic [2:0] F3_MULH   = 3'd1;
    localparam logic [2:0] F3_MULHSU = 3'd2;
    localparam logic [2:0] F3_MULHU  = 3'd3;
    localparam logic [2:0] F3_DIV    = 3'd4;
    localparam logic [2:0] F3_DIVU   = 3'd5;
    localparam logic [2:0] F3_REM    = 3'd6;
    localparam logic [2:0] F3_REMU   = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int cnt_width(input int xlen);
        return $clog2(xlen) + 1;
    endfunction
endpackage

// File: rtl/alu_mdu_if.sv
// Request/response bundle between the execute control path and alu_mdu.
// Latency: wires only.
// Backpressure: in_valid/in_ready on the request side, out_valid/out_ready on the result side.
interface alu_mdu_if
    import alu_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
);
    logic            in_valid;
    logic            in_ready;
    logic [4:0]      op;
    logic [XLEN-1:0] data1;
    logic [XLEN-1:0] data2;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            zero;
    logic            illegal;

    modport master (
        output in_valid, op, data1, data2, out_ready,
        input  in_ready, out_valid, result, zero, illegal
    );

    modport slave (
        input  in_valid, op, data1, data2, out_ready,
        output in_ready, out_valid, result, zero, illegal
    );
endinterface

// File: rtl/mdu_iter.sv
// Iterative multiply (radix-2 shift-add) and, with ALU_MDU_DIV_EN, restoring divide on magnitudes.
// Latency: XLEN iterations after start; done pulses on the last one with res valid that cycle.
// Backpressure: none; the owner issues start only when idle.
module mdu_iter
    import alu_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
)(
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      f3,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            done,
    output logic [XLEN-1:0] res
);
    localparam int CNT_W = cnt_width(XLEN);

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [XLEN-1:0]   acc_q, acc_d, lo_q, lo_d, opb_q, opb_d;
    logic [2:0]        f3_q, f3_d;
    logic              neg_q, neg_d;
    logic              a_neg, b_neg;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic [XLEN:0]     sum;
    logic [2*XLEN-1:0] prod, pfix;
`ifdef ALU_MDU_DIV_EN
    logic [XLEN:0]     rs;
    logic [XLEN-1:0]   dres;
`endif

    always_comb begin
        a_neg = a[XLEN-1] & (f3 inside {F3_MULH, F3_MULHSU, F3_DIV, F3_REM});
        b_neg = b[XLEN-1] & !(f3 inside {F3_MUL, F3_MULHSU, F3_MULHU, F3_DIVU, F3_REMU});
        a_mag = a_neg ? -a : a;
        b_mag = b_neg ? -b : b;
    end

    always_comb begin
        cnt_d = cnt_q;
        acc_d = acc_q;
        lo_d  = lo_q;
        opb_d = opb_q;
        f3_d  = f3_q;
        neg_d = neg_q;
        sum   = '0;
`ifdef ALU_MDU_DIV_EN
        rs    = '0;
`endif
        if (start) begin
            cnt_d = CNT_W'(XLEN);
            acc_d = '0;
            f3_d  = f3;
            // Remainder follows the dividend; everything else is the product/quotient sign.
            neg_d = (f3[2] & f3[1]) ? a_neg : (a_neg ^ b_neg);
            opb_d = f3[2] ? b_mag : a_mag;
            lo_d  = f3[2] ? a_mag : b_mag;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
`ifdef ALU_MDU_DIV_EN
            if (f3_q[2]) begin
                rs = {acc_q, lo_q[XLEN-1]};
                if (rs >= {1'b0, opb_q}) begin
                    acc_d = rs[XLEN-1:0] - opb_q;
                    lo_d  = {lo_q[XLEN-2:0], 1'b1};
                end else begin
                    acc_d = rs[XLEN-1:0];
                    lo_d  = {lo_q[XLEN-2:0], 1'b0};
                end
            end else
`endif
            begin
                sum   = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
                acc_d = sum[XLEN:1];
                lo_d  = {sum[0], lo_q[XLEN-1:1]};
            end
        end
    end

    // Result is taken from the final iteration's next-state so the top can latch it on that edge.
    always_comb begin
        prod = {acc_d, lo_d};
        pfix = neg_q ? -prod : prod;
        res  = (f3_q == F3_MUL) ? pfix[XLEN-1:0] : pfix[2*XLEN-1:XLEN];
`ifdef ALU_MDU_DIV_EN
        dres = f3_q[1] ? acc_d : lo_d;
        if (f3_q[2]) begin
            res = neg_q ? -dres : dres;
        end
`endif
    end

    assign done = (cnt_q == CNT_W'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            acc_q <= '0;
            lo_q  <= '0;
            opb_q <= '0;
            f3_q  <= '0;
            neg_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            acc_q <= acc_d;
            lo_q  <= lo_d;
            opb_q <= opb_d;
            f3_q  <= f3_d;
            neg_q <= neg_d;
        end
    end
endmodule

// File: rtl/alu_mdu.sv
// Execute-stage integer ALU plus iterative M-extension unit; divider present only with ALU_MDU_DIV_EN.
// Latency: 1 cycle for base/illegal/div-corner ops, XLEN+1 cycles for iterative MUL*/DIV*/REM*.
// Backpressure: one op in flight; result held in DONE until out_ready, in_ready only in IDLE.
module alu_mdu
    import alu_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
)(
    input  logic      clk,
    input  logic      rst,
    alu_mdu_if.slave  bus
);
    localparam int SH_W = $clog2(XLEN);

    state_e          state_q, state_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            zero_q, zero_d;
    logic            illegal_q, illegal_d;
    logic            start, mdu_done, m_legal, base_legal;
    logic [XLEN-1:0] mdu_res, base_res;
    logic [SH_W-1:0] shamt;
`ifdef ALU_MDU_DIV_EN
    logic            div_zero, div_ovf;
    logic [XLEN-1:0] div_spec_res;

    assign m_legal      = ~bus.op[3];
    assign div_zero     = bus.op[2] & (bus.data2 == '0);
    assign div_ovf      = bus.op[2] & ~bus.op[0] & (&bus.data2)
                        & (bus.data1 == {1'b1, {(XLEN-1){1'b0}}});
    assign div_spec_res = div_zero ? (bus.op[1] ? bus.data1 : '1)
                                   : (bus.op[1] ? '0 : bus.data1);
`else
    assign m_legal = ~bus.op[3] & ~bus.op[2];
`endif

    mdu_iter #(.XLEN(XLEN)) u_mdu_iter (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .f3    (bus.op[2:0]),
        .a     (bus.data1),
        .b     (bus.data2),
        .done  (mdu_done),
        .res   (mdu_res)
    );

    always_comb begin
        shamt      = bus.data2[SH_W-1:0];
        base_res   = '0;
        base_legal = 1'b1;
        case (bus.op[3:0])
            OP_ADD:  base_res = bus.data1 + bus.data2;
            OP_SUB:  base_res = bus.data1 - bus.data2;
            OP_SLL:  base_res = bus.data1 << shamt;
            OP_SLT:  base_res = XLEN'($signed(bus.data1) < $signed(bus.data2));
            OP_SLTU: base_res = XLEN'(bus.data1 < bus.data2);
            OP_XOR:  base_res = bus.data1 ^ bus.data2;
            OP_SRL:  base_res = bus.data1 >> shamt;
            OP_SRA:  base_res = $unsigned($signed(bus.data1) >>> shamt);
            OP_OR:   base_res = bus.data1 | bus.data2;
            OP_AND:  base_res = bus.data1 & bus.data2;
            default: base_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        illegal_d = illegal_q;
        start     = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    state_d   = DONE;
                    illegal_d = 1'b0;
                    if (!bus.op[4]) begin
                        result_d  = base_res;
                        illegal_d = ~base_legal;
                    end else if (!m_legal) begin
                        result_d  = '0;
                        illegal_d = 1'b1;
                    end
`ifdef ALU_MDU_DIV_EN
                    else if (div_zero | div_ovf) begin
                        result_d = div_spec_res;
                    end
`endif
                    else begin
                        state_d = BUSY;
                        start   = 1'b1;
                    end
                end
            end
            BUSY: begin
                if (mdu_done) begin
                    state_d  = DONE;
                    result_d = mdu_res;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        zero_d = (result_d == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            result_q  <= '0;
            zero_q    <= 1'b1;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            illegal_q <= illegal_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.result    = result_q;
    assign bus.zero      = zero_q;
    assign bus.illegal   = illegal_q;
endmodule
